robm_shadow_monitor: RTL and testbench
======================================

ROBM_SHADOW_MONITOR -- requirements
Module: robm_shadow_monitor

Interface
REQ-001 SHALL expose parameter STALL_MAX, default 255: consecutive no-progress samples in S4/S7 before stall_o asserts (range 1..255).
REQ-002 SHALL have port clk, input, 1, the one clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port smp_en, input, 1, sample qualifier: the monitor acts only on cycles with smp_en=1.
REQ-005 SHALL have port y, input, 10, observed robm output vector; y[0]=y1 ... y[9]=y10.
REQ-006 SHALL have port state_o, output, 3, tracked controller state: 0=HUNT, 1..7=S1..S7, with S6 covering both key paths.
REQ-007 SHALL have port err_o, output, 1, sticky illegal-pattern flag.
REQ-008 SHALL have port err_state_o, output, 3, value of state_o when the first error was seen.
REQ-009 SHALL have port trans_cnt_o, output, 16, count of tracked state changes, saturating.
REQ-010 SHALL have port stall_o, output, 1, no-progress indicator.

Function
REQ-011 SHALL act as the observing end of the robm controller: it reconstructs the controller state from y alone, one sample per smp_en cycle, and updates outputs on the same posedge (1-cycle latency).
REQ-012 SHALL apply the following legal pattern -> next-state table; any bit not listed must be 0:
 - S1: {} -> S1; {y4} -> S2; {y7,y8} -> S3; {y1,y2} or {y2,y3} -> S4; {y10} -> S5.
 - S2: {y5} -> S1.
 - S3: {y6} -> S6.
 - S4: {} -> S4; {y4} -> S2.
 - S5: {y2,y9} -> S7; {y2,y3} -> S4.
 - S6: {y1,y2} or {y2,y3} -> S4; {y4} -> S2.
 - S7: {} -> S7; {y2,y3} -> S4.
REQ-013 SHALL, on any pattern not listed for the current state (S1..S7), set err_o=1, load err_state_o with the current state only if err_o was 0, and move to HUNT.
REQ-014 SHALL, in HUNT, stay in HUNT for every pattern except exactly {y5}, which moves to S1 (resynchronised); errors are not re-flagged while in HUNT.
REQ-015 SHALL increment trans_cnt_o by 1 on every sample where next state != current state, including entries to and exits from HUNT; it saturates at 16'hFFFF with no wrap.
REQ-016 SHALL keep an 8-bit stall counter: +1 on each sample in S4 or S7 where the state is unchanged, cleared on any state change, saturating at 255.
REQ-017 SHALL drive stall_o=1 while stall counter >= STALL_MAX, combinationally from the registered counter, and drop it on the first state change.
REQ-018 SHALL hold all state, counters and outputs unchanged on cycles with smp_en=0, whatever the value of y.
REQ-019 SHALL clear err_o only by reset; it stays 1 across resync.

Reset
REQ-020 SHALL, while rst=0, immediately force state_o=1 (S1), err_o=0, err_state_o=0, trans_cnt_o=0, stall counter=0, stall_o=0, independent of clk.
REQ-021 SHALL, on rst asserting mid-operation (including while in HUNT or stalled), discard all history; the first sample after rst releases is evaluated from S1.

Verification
REQ-022 Legal walk: from reset, sample y4, y5, y7|y8, y6, y2|y3, y4, y5 -> state_o S2,S1,S3,S6,S4,S2,S1; trans_cnt_o=7; err_o=0.
REQ-023 Illegal pattern: in S2, sample {y6} -> state_o=0, err_o=1, err_state_o=2; then {y1} -> stays 0; then {y5} -> state_o=1; err_o stays 1; trans_cnt_o counts +2.
REQ-024 Stall: STALL_MAX=4; reach S4, then 4 samples of y=0 -> stall_o=1 after the 4th; then {y4} -> state_o=2, stall_o=0.
REQ-025 smp_en gating: in S1, y={y4} held with smp_en=0 for 10 cycles -> state_o stays 1, trans_cnt_o unchanged; one smp_en=1 cycle -> S2.
REQ-026 Saturation: force 65535 transitions (or preload in a test mode) then one more change -> trans_cnt_o stays 16'hFFFF.
REQ-027 Async reset: with err_o=1 and state S7, drive rst=0 between clock edges -> all outputs reset at once, before the next posedge.

Source files
------------

// File: rtl/robm_shadow_monitor.sv
// ---------------------------------------------------------------------------
// robm_shadow_monitor
//
// Passive observer of the robm controller. It rebuilds the controller state
// from the observed output vector y alone. The vector is sampled once per
// smp_en cycle, and the tracked state is published one clock later. A pattern
// that is not legal from the tracked state raises a sticky error and drops
// the tracker into HUNT. HUNT waits for a lone y5, which the controller only
// emits on its way back to S1.
//
// Ports
//   clk          : the one clock, rising edge
//   rst          : asynchronous active-low reset
//   smp_en       : sample qualifier; nothing changes while it is low
//   y[9:0]       : observed controller outputs, y[0]=y1 ... y[9]=y10
//   state_o[2:0] : tracked state, 0=HUNT, 1..7=S1..S7
//   err_o        : sticky illegal-pattern flag (cleared only by rst)
//   err_state_o  : tracked state at the moment of the first error
//   trans_cnt_o  : saturating count of tracked state changes
//   stall_o      : no-progress indicator for the waiting states S4/S7
// ---------------------------------------------------------------------------
module robm_shadow_monitor #(
   parameter int unsigned STALL_MAX = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        smp_en,
   input  logic [9:0]  y,
   output logic [2:0]  state_o,
   output logic        err_o,
   output logic [2:0]  err_state_o,
   output logic [15:0] trans_cnt_o,
   output logic        stall_o
);

   localparam logic [2:0] ST_HUNT = 3'd0;
   localparam logic [2:0] ST_S1   = 3'd1;
   localparam logic [2:0] ST_S2   = 3'd2;
   localparam logic [2:0] ST_S3   = 3'd3;
   localparam logic [2:0] ST_S4   = 3'd4;
   localparam logic [2:0] ST_S5   = 3'd5;
   localparam logic [2:0] ST_S6   = 3'd6;
   localparam logic [2:0] ST_S7   = 3'd7;

   // Observed patterns; each constant is the complete vector, all other bits 0
   localparam logic [9:0] P_NONE = 10'h000;
   localparam logic [9:0] P_Y1Y2 = 10'h003;
   localparam logic [9:0] P_Y2Y3 = 10'h006;
   localparam logic [9:0] P_Y4   = 10'h008;
   localparam logic [9:0] P_Y5   = 10'h010;
   localparam logic [9:0] P_Y6   = 10'h020;
   localparam logic [9:0] P_Y7Y8 = 10'h0C0;
   localparam logic [9:0] P_Y2Y9 = 10'h102;
   localparam logic [9:0] P_Y10  = 10'h200;

   localparam logic [7:0]  STALL_LIM = 8'(STALL_MAX);
   localparam logic [7:0]  STALL_SAT = 8'hFF;
   localparam logic [15:0] TRANS_SAT = 16'hFFFF;

   logic [2:0]  state_r;
   logic        err_r;
   logic [2:0]  err_state_r;
   logic [15:0] trans_cnt_r;
   logic [7:0]  stall_cnt_r;

   logic [2:0]  nxt_state_s;
   logic        illegal_s;
   logic        changed_s;
   logic        waiting_s;

   // Tracked-state register; only a qualified sample may move it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_S1;
      end else if (smp_en) begin
         state_r <= nxt_state_s;
      end
   end

   // Legal pattern table; anything unlisted from S1..S7 is an error and leads to HUNT
   always_comb begin
      nxt_state_s = state_r;
      illegal_s   = 1'b0;
      case (state_r)
         ST_HUNT: begin
            // Only a lone y5 resynchronises; HUNT itself never flags errors
            if (y == P_Y5) begin
               nxt_state_s = ST_S1;
            end else begin
               nxt_state_s = ST_HUNT;
            end
         end
         ST_S1: begin
            case (y)
               P_NONE:         nxt_state_s = ST_S1;
               P_Y4:           nxt_state_s = ST_S2;
               P_Y7Y8:         nxt_state_s = ST_S3;
               P_Y1Y2, P_Y2Y3: nxt_state_s = ST_S4;
               P_Y10:          nxt_state_s = ST_S5;
               default:        illegal_s   = 1'b1;
            endcase
         end
         ST_S2: begin
            case (y)
               P_Y5:    nxt_state_s = ST_S1;
               default: illegal_s   = 1'b1;
            endcase
         end
         ST_S3: begin
            case (y)
               P_Y6:    nxt_state_s = ST_S6;
               default: illegal_s   = 1'b1;
            endcase
         end
         ST_S4: begin
            case (y)
               P_NONE:  nxt_state_s = ST_S4;
               P_Y4:    nxt_state_s = ST_S2;
               default: illegal_s   = 1'b1;
            endcase
         end
         ST_S5: begin
            case (y)
               P_Y2Y9:  nxt_state_s = ST_S7;
               P_Y2Y3:  nxt_state_s = ST_S4;
               default: illegal_s   = 1'b1;
            endcase
         end
         ST_S6: begin
            case (y)
               P_Y1Y2, P_Y2Y3: nxt_state_s = ST_S4;
               P_Y4:           nxt_state_s = ST_S2;
               default:        illegal_s   = 1'b1;
            endcase
         end
         ST_S7: begin
            case (y)
               P_NONE:  nxt_state_s = ST_S7;
               P_Y2Y3:  nxt_state_s = ST_S4;
               default: illegal_s   = 1'b1;
            endcase
         end
         default: illegal_s = 1'b1;
      endcase
      if (illegal_s) begin
         nxt_state_s = ST_HUNT;
      end else begin
         nxt_state_s = nxt_state_s;
      end
   end

   assign changed_s = (nxt_state_s != state_r);
   assign waiting_s = (state_r == ST_S4) || (state_r == ST_S7);

   // Sticky error flag; err_state captures only the first offending state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_r       <= 1'b0;
         err_state_r <= 3'd0;
      end else if (smp_en && illegal_s) begin
         err_r <= 1'b1;
         if (!err_r) begin
            err_state_r <= state_r;
         end
      end
   end

   // Transition counter, saturating; HUNT entries and exits count as changes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         trans_cnt_r <= 16'd0;
      end else if (smp_en && changed_s && (trans_cnt_r != TRANS_SAT)) begin
         trans_cnt_r <= trans_cnt_r + 16'd1;
      end
   end

   // No-progress run length in S4/S7, cleared by any change, saturating
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_r <= 8'd0;
      end else if (smp_en) begin
         if (changed_s) begin
            stall_cnt_r <= 8'd0;
         end else if (waiting_s && (stall_cnt_r != STALL_SAT)) begin
            stall_cnt_r <= stall_cnt_r + 8'd1;
         end
      end
   end

   // Output decode; stall is a pure compare on the registered run length
   always_comb begin
      state_o     = state_r;
      err_o       = err_r;
      err_state_o = err_state_r;
      trans_cnt_o = trans_cnt_r;
      if (stall_cnt_r >= STALL_LIM) begin
         stall_o = 1'b1;
      end else begin
         stall_o = 1'b0;
      end
   end

endmodule

// File: tb/tb_robm_shadow_monitor.sv
// ---------------------------------------------------------------------------
// tb_robm_shadow_monitor
//
// Bench for robm_shadow_monitor, built with STALL_MAX=4. A behavioural model
// holds the legal transitions as a list of (state, pattern, next) rules and
// updates plain integers each sample. One compare process checks every DUT
// output against the model on each falling clock edge. Directed scenarios add
// hand-computed literal expectations, and a randomised phase follows them.
// ---------------------------------------------------------------------------
module tb_robm_shadow_monitor;

   localparam int SMAX = 4;

   logic        clk;
   logic        rst;
   logic        smp_en;
   logic [9:0]  y;
   logic [2:0]  state_o;
   logic        err_o;
   logic [2:0]  err_state_o;
   logic [15:0] trans_cnt_o;
   logic        stall_o;

   robm_shadow_monitor #(.STALL_MAX(SMAX)) dut (
      .clk         (clk),
      .rst         (rst),
      .smp_en      (smp_en),
      .y           (y),
      .state_o     (state_o),
      .err_o       (err_o),
      .err_state_o (err_state_o),
      .trans_cnt_o (trans_cnt_o),
      .stall_o     (stall_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Pattern names (y1 = bit 0)
   localparam logic [9:0] Y0    = 10'h000;
   localparam logic [9:0] Y1    = 10'h001;
   localparam logic [9:0] Y1Y2  = 10'h003;
   localparam logic [9:0] Y2Y3  = 10'h006;
   localparam logic [9:0] Y4    = 10'h008;
   localparam logic [9:0] Y5    = 10'h010;
   localparam logic [9:0] Y6    = 10'h020;
   localparam logic [9:0] Y7Y8  = 10'h0C0;
   localparam logic [9:0] Y2Y9  = 10'h102;
   localparam logic [9:0] Y10   = 10'h200;
   localparam logic [9:0] YALL  = 10'h3FF;

   typedef struct {
      int         s;
      logic [9:0] p;
      int         n;
   } rule_t;

   rule_t      rules[$];
   logic [9:0] pats[9];

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_on   = 1'b0;

   // Behavioural model state
   int m_state;
   int m_err;
   int m_err_state;
   int m_cnt;
   int m_stall;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lookup(input int s, input logic [9:0] p);
      int r;
      r = -1;
      foreach (rules[i]) begin
         if (rules[i].s == s && rules[i].p == p) r = rules[i].n;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_state     = 1;
      m_err       = 0;
      m_err_state = 0;
      m_cnt       = 0;
      m_stall     = 0;
   endtask

   task automatic model_step(input logic [9:0] yy);
      int nxt;
      if (m_state == 0) begin
         nxt = (yy == Y5) ? 1 : 0;
      end else begin
         nxt = lookup(m_state, yy);
         if (nxt < 0) begin
            if (m_err == 0) m_err_state = m_state;
            m_err = 1;
            nxt   = 0;
         end
      end
      if (nxt != m_state) begin
         if (m_cnt < 65535) m_cnt++;
         m_stall = 0;
      end else if (m_state == 4 || m_state == 7) begin
         if (m_stall < 255) m_stall++;
      end
      m_state = nxt;
   endtask

   // One sample cycle: drive on the falling edge, update the model at the rising edge
   task automatic step(input logic en, input logic [9:0] yy);
      @(negedge clk);
      smp_en = en;
      y      = yy;
      @(posedge clk);
      if (en) model_step(yy);
      #1;
   endtask

   // Reset asserted between edges; outputs must respond before any clock edge
   task automatic async_reset();
      @(negedge clk);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("rst_state", {29'd0, state_o}, 32'd1);
      check("rst_err", {31'd0, err_o}, 32'd0);
      check("rst_err_state", {29'd0, err_state_o}, 32'd0);
      check("rst_cnt", {16'd0, trans_cnt_o}, 32'd0);
      check("rst_stall", {31'd0, stall_o}, 32'd0);
      smp_en = 1'b0;
      @(negedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (cmp_on) begin
         check("state_o", {29'd0, state_o}, m_state);
         check("err_o", {31'd0, err_o}, m_err);
         check("err_state_o", {29'd0, err_state_o}, m_err_state);
         check("trans_cnt_o", {16'd0, trans_cnt_o}, m_cnt);
         check("stall_o", {31'd0, stall_o}, (m_stall >= SMAX) ? 32'd1 : 32'd0);
      end
   end

   initial begin
      logic [31:0] r;
      logic [9:0]  yy;

      rules.push_back('{1, Y0,   1});
      rules.push_back('{1, Y4,   2});
      rules.push_back('{1, Y7Y8, 3});
      rules.push_back('{1, Y1Y2, 4});
      rules.push_back('{1, Y2Y3, 4});
      rules.push_back('{1, Y10,  5});
      rules.push_back('{2, Y5,   1});
      rules.push_back('{3, Y6,   6});
      rules.push_back('{4, Y0,   4});
      rules.push_back('{4, Y4,   2});
      rules.push_back('{5, Y2Y9, 7});
      rules.push_back('{5, Y2Y3, 4});
      rules.push_back('{6, Y1Y2, 4});
      rules.push_back('{6, Y2Y3, 4});
      rules.push_back('{6, Y4,   2});
      rules.push_back('{7, Y0,   7});
      rules.push_back('{7, Y2Y3, 4});
      pats = '{Y0, Y4, Y5, Y6, Y7Y8, Y1Y2, Y2Y3, Y10, Y2Y9};

      rst    = 1'b0;
      smp_en = 1'b0;
      y      = Y0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("init_state", {29'd0, state_o}, 32'd1);
      check("init_cnt", {16'd0, trans_cnt_o}, 32'd0);
      check("init_err", {31'd0, err_o}, 32'd0);
      @(negedge clk);
      rst    = 1'b1;
      cmp_on = 1'b1;

      // Legal walk
      step(1'b1, Y4);   check("walk1", {29'd0, state_o}, 32'd2);
      step(1'b1, Y5);   check("walk2", {29'd0, state_o}, 32'd1);
      step(1'b1, Y7Y8); check("walk3", {29'd0, state_o}, 32'd3);
      step(1'b1, Y6);   check("walk4", {29'd0, state_o}, 32'd6);
      step(1'b1, Y2Y3); check("walk5", {29'd0, state_o}, 32'd4);
      step(1'b1, Y4);   check("walk6", {29'd0, state_o}, 32'd2);
      step(1'b1, Y5);   check("walk7", {29'd0, state_o}, 32'd1);
      check("walk_cnt", {16'd0, trans_cnt_o}, 32'd7);
      check("walk_err", {31'd0, err_o}, 32'd0);

      // Illegal pattern in S2, HUNT, resync
      step(1'b1, Y4);
      step(1'b1, Y6);
      check("ill_state", {29'd0, state_o}, 32'd0);
      check("ill_err", {31'd0, err_o}, 32'd1);
      check("ill_err_state", {29'd0, err_state_o}, 32'd2);
      step(1'b1, Y1);   check("hunt_stay", {29'd0, state_o}, 32'd0);
      step(1'b1, Y5);   check("resync", {29'd0, state_o}, 32'd1);
      check("resync_err", {31'd0, err_o}, 32'd1);
      check("resync_cnt", {16'd0, trans_cnt_o}, 32'd10);

      // smp_en gating
      async_reset();
      for (int i = 0; i < 10; i++) step(1'b0, Y4);
      check("gate_state", {29'd0, state_o}, 32'd1);
      check("gate_cnt", {16'd0, trans_cnt_o}, 32'd0);
      step(1'b1, Y4);   check("gate_go", {29'd0, state_o}, 32'd2);

      // Stall in S4
      step(1'b1, Y5);
      step(1'b1, Y1Y2); check("stall_s4", {29'd0, state_o}, 32'd4);
      step(1'b1, Y0);
      step(1'b1, Y0);
      step(1'b1, Y0);   check("stall_3", {31'd0, stall_o}, 32'd0);
      step(1'b1, Y0);   check("stall_4", {31'd0, stall_o}, 32'd1);
      step(1'b1, Y4);
      check("stall_exit_state", {29'd0, state_o}, 32'd2);
      check("stall_exit", {31'd0, stall_o}, 32'd0);

      // Error, then S7, then async reset
      step(1'b1, Y5);
      step(1'b1, YALL); check("err2_err_state", {29'd0, err_state_o}, 32'd1);
      step(1'b1, Y5);
      step(1'b1, Y10);
      step(1'b1, Y2Y9); check("s7_state", {29'd0, state_o}, 32'd7);
      check("s7_err", {31'd0, err_o}, 32'd1);
      async_reset();

      // Randomised phase
      for (int i = 0; i < 2000; i++) begin
         r = $urandom;
         case (r[3:0] % 4'd10)
            4'd7:    yy = r[13:4];
            4'd8:    yy = 10'd1 << (r[7:4] % 4'd10);
            default: yy = pats[r[11:4] % 8'd9];
         endcase
         if (r[31:24] == 8'd0) begin
            async_reset();
         end else begin
            step(r[21:20] != 2'd0, yy);
         end
      end

      // Transition counter saturation
      async_reset();
      for (int i = 0; i < 65535; i++) step(1'b1, (i % 2 == 0) ? Y4 : Y5);
      check("sat_reach", {16'd0, trans_cnt_o}, 32'h0000FFFF);
      step(1'b1, Y4);
      check("sat_hold", {16'd0, trans_cnt_o}, 32'h0000FFFF);

      @(negedge clk);
      cmp_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
